// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: holds downstream logic in reset until the PLL lock
// flag has been stable for a while, then releases it and watches a divided
// PLL heartbeat. Lock loss or a stalled heartbeat drops back to reset and is
// counted; a stalled heartbeat also raises a sticky fault.
module pll_lock_supervisor #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int WDOG_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock,
    input  logic       hb_in,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic       fault
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] WDOG_LAST   = 16'(WDOG_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [15:0] wdog;
    logic [15:0] wdog_nxt;
    logic        lock_meta;
    logic        lock_s;
    logic        hb_meta;
    logic        hb_s;
    logic        hb_prev;
    logic        hb_edge;
    logic        loss_evt;
    logic        tmo_evt;
    logic        sys_reset_nxt;
    logic        ready_nxt;

    // Saturating increment so the event counter sticks at its maximum.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchronizers for lock and heartbeat, plus the heartbeat history flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            hb_meta   <= 1'b0;
            hb_s      <= 1'b0;
            hb_prev   <= 1'b0;
        end else begin
            lock_meta <= lock;
            lock_s    <= lock_meta;
            hb_meta   <= hb_in;
            hb_s      <= hb_meta;
            hb_prev   <= hb_s;
        end
    end

    assign hb_edge = hb_s ^ hb_prev;

    // State, cycle counter and watchdog registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wdog  <= wdog_nxt;
        end
    end

    // Next-state logic; lock loss takes priority over counter completion.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wdog_nxt  = '0;
        loss_evt  = 1'b0;
        tmo_evt   = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lock_s) state_nxt = STABILIZE;
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                    loss_evt  = 1'b1;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RUN: begin
                cnt_nxt  = '0;
                tmo_evt  = !hb_edge && (wdog == WDOG_LAST);
                wdog_nxt = hb_edge ? 16'd0 : wdog + 16'd1;
                if (!lock_s || tmo_evt) begin
                    state_nxt = WAIT_LOCK;
                    wdog_nxt  = '0;
                    loss_evt  = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        sys_reset_nxt = (state_nxt != RUN);
        ready_nxt     = (state_nxt == RUN);
    end

    // Registered outputs: reset/ready flags, saturating loss counter, sticky fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
            loss_count <= 8'd0;
            fault      <= 1'b0;
        end else begin
            sys_reset <= sys_reset_nxt;
            ready     <= ready_nxt;
            if (loss_evt) loss_count <= sat_inc(loss_count);
            if (tmo_evt)  fault      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with STABLE=8, HOLD=4, WDOG=6.
module tb_pll_lock_supervisor;

    localparam int STABLE = 8;
    localparam int HOLD   = 4;
    localparam int WDOG   = 6;
    localparam int LAT    = 2 + 1 + STABLE + HOLD;
    localparam int WAIT_MAX = 60;

    logic       clk;
    logic       reset;
    logic       lock;
    logic       hb_in;
    logic       sys_reset;
    logic       ready;
    logic [7:0] loss_count;
    logic       fault;

    logic hb_run;
    logic hb_ph;

    int n_checks;
    int n_fail;

    typedef struct {
        string tag;
        int    sr;
        int    rd;
        int    lc;
        int    ft;
    } exp_t;

    exp_t sb[$];

    pll_lock_supervisor #(
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLD),
        .WDOG_CYCLES  (WDOG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .lock      (lock),
        .hb_in     (hb_in),
        .sys_reset (sys_reset),
        .ready     (ready),
        .loss_count(loss_count),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Heartbeat source: hb_in toggles every 2 clock cycles while hb_run is set.
    initial begin
        hb_in = 1'b0;
        hb_ph = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (hb_run) begin
                hb_ph = ~hb_ph;
                if (hb_ph) hb_in = ~hb_in;
            end
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input int sr, input int rd, input int lc, input int ft);
        exp_t e;
        e.tag = tag;
        e.sr  = sr;
        e.rd  = rd;
        e.lc  = lc;
        e.ft  = ft;
        sb.push_back(e);
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".sys_reset"}, int'(sys_reset), e.sr);
            chk({e.tag, ".ready"}, int'(ready), e.rd);
            chk({e.tag, ".loss_count"}, int'(loss_count), e.lc);
            chk({e.tag, ".fault"}, int'(fault), e.ft);
        end
    endtask

    // Counts cycles until sys_reset falls, giving up after WAIT_MAX.
    task automatic wait_sys_low(output int n);
        n = 0;
        while (sys_reset !== 1'b0 && n < WAIT_MAX) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        lock     = 1'b0;
        hb_run   = 1'b1;

        // Reset state.
        tick(3);
        push_exp("reset", 1, 0, 0, 0);
        compare_next();

        // Lock rises with heartbeat running: release after the full latency.
        reset = 1'b0;
        tick(5);
        lock = 1'b1;
        wait_sys_low(n);
        chk("first_lock_latency", n, LAT);
        push_exp("run_entry", 0, 1, 0, 0);
        compare_next();
        tick(20);
        push_exp("run_steady", 0, 1, 0, 0);
        compare_next();

        // Lock falls in RUN: sys_reset returns on the third cycle.
        lock = 1'b0;
        tick(2);
        push_exp("lock_fall_2", 0, 1, 0, 0);
        compare_next();
        tick(1);
        push_exp("lock_fall_3", 1, 0, 1, 0);
        compare_next();

        // One-cycle lock glitch at STABILIZE count 5: full restart, no count.
        lock = 1'b1;
        tick(6);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        wait_sys_low(n);
        chk("glitch_restart_latency", n, LAT);
        push_exp("glitch_run", 0, 1, 1, 0);
        compare_next();

        // Heartbeat frozen in RUN: watchdog timeout sets fault and counts.
        tick(4);
        hb_run = 1'b0;
        tick(6);
        push_exp("hb_frozen_6", 0, 1, 1, 0);
        compare_next();
        tick(2);
        push_exp("hb_timeout", 1, 0, 2, 1);
        compare_next();
        hb_run = 1'b1;
        wait_sys_low(n);
        chk("relock_after_fault", int'(n < WAIT_MAX), 1);
        push_exp("fault_sticky", 0, 1, 2, 1);
        compare_next();

        // Reset pulsed during HOLD.
        lock = 1'b0;
        tick(4);
        push_exp("lock_lost_again", 1, 0, 3, 1);
        compare_next();
        lock = 1'b1;
        tick(13);
        push_exp("in_hold", 1, 0, 3, 1);
        compare_next();
        reset = 1'b1;
        tick(1);
        push_exp("reset_in_hold", 1, 0, 0, 0);
        compare_next();
        reset = 1'b0;
        wait_sys_low(n);
        chk("post_reset_latency", n, LAT);
        push_exp("post_reset_run", 0, 1, 0, 0);
        compare_next();

        // 300 lock-loss events: counter saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            lock = 1'b0;
            tick(3);
            if (i == 254) chk("loss_count_254", int'(loss_count), 254);
            lock = 1'b1;
            wait_sys_low(n);
            if (n >= WAIT_MAX) chk("relock_timeout", n, LAT);
        end
        push_exp("saturated", 0, 1, 255, 0);
        compare_next();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
